asp_irq_ctrl: RTL and testbench

Host-facing interrupt controller for the ASP. It collects the level-sensitive IRQ sources (DMA_0 on bit 0, kernel on bit 1, DMA_1 on bit 2, bit 3 spare) and latches their rising edges into pending bits. Each pending, unmasked source is delivered as one vector request over a valid/ack handshake toward the FIM MSI path. Host software sees pending, mask and count state through a small AVMM CSR responder on the MMIO path.

---
 rtl/asp_irq_ctrl_if.sv | 32 +++
 rtl/asp_irq_ctrl.sv | 142 ++++++++++++++
 tb/tb_asp_irq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/asp_irq_ctrl_if.sv
// Bundle for the ASP interrupt controller: IRQ sources, AVMM CSR port and
// the vector request handshake toward the MSI path.
interface asp_irq_ctrl_if #(
  parameter int NUM_IRQ_LINES  = 4,
  parameter int CSR_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 3
);
  localparam int VEC_W = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1;

  logic [NUM_IRQ_LINES-1:0]    irq_in;
  logic [CSR_ADDR_WIDTH-1:0]   csr_address;
  logic                        csr_read;
  logic                        csr_write;
  logic [CSR_DATA_WIDTH-1:0]   csr_writedata;
  logic [CSR_DATA_WIDTH/8-1:0] csr_byteenable;
  logic [CSR_DATA_WIDTH-1:0]   csr_readdata;
  logic                        csr_readdatavalid;
  logic                        csr_waitrequest;
  logic                        irq_req;
  logic [VEC_W-1:0]            irq_vector;
  logic                        irq_ack;

  modport slave (
    input  irq_in, csr_address, csr_read, csr_write, csr_writedata, csr_byteenable, irq_ack,
    output csr_readdata, csr_readdatavalid, csr_waitrequest, irq_req, irq_vector
  );

  modport master (
    output irq_in, csr_address, csr_read, csr_write, csr_writedata, csr_byteenable, irq_ack,
    input  csr_readdata, csr_readdatavalid, csr_waitrequest, irq_req, irq_vector
  );
endinterface

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: latches source rising edges, issues one vector
// request per pending unmasked source, exposes state over an AVMM CSR port.
module asp_irq_ctrl #(
  parameter int NUM_IRQ_LINES  = 4,
  parameter int NUM_IRQ_USED   = 3,
  parameter int CSR_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 3,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  asp_irq_ctrl_if.slave    bus
);
  localparam int N     = NUM_IRQ_LINES;
  localparam int VEC_W = (N > 1) ? $clog2(N) : 1;
  localparam int HW    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CSR_ADDR_WIDTH-1:0] A_STATUS = CSR_ADDR_WIDTH'(0);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_CLEAR  = CSR_ADDR_WIDTH'(1);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MASK   = CSR_ADDR_WIDTH'(2);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_SENT   = CSR_ADDR_WIDTH'(3);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_COUNT  = CSR_ADDR_WIDTH'(4);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_RAW    = CSR_ADDR_WIDTH'(5);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t              state, state_nxt;
  logic [N-1:0]        irq_prev, pending, sent, mask_r, spare_m;
  logic [N-1:0]        rise, clr, mask_eff, eligible, ack_oh;
  logic [31:0]         count;
  logic [HW-1:0]       hold_cnt;
  logic [VEC_W-1:0]    vec_r, low_idx;
  logic                wr_en, acked, load_vec;
  logic [CSR_DATA_WIDTH-1:0] rd_mux, rd_data;
  logic                rd_vld;
  logic                unused_bits;

  for (genvar gi = 0; gi < N; gi++) begin : g_spare
    assign spare_m[gi] = (gi >= NUM_IRQ_USED);
  end

  assign rise     = bus.irq_in & ~irq_prev;
  assign wr_en    = bus.csr_write & bus.csr_byteenable[0];
  assign clr      = (wr_en && bus.csr_address == A_CLEAR) ? bus.csr_writedata[N-1:0] : '0;
  assign mask_eff = mask_r | spare_m;
  assign eligible = pending & ~mask_eff & ~sent;
  assign acked    = (state == REQ) && bus.irq_ack;
  assign ack_oh   = acked ? (N'(1) << vec_r) : '0;

  assign unused_bits = ^{bus.csr_writedata[CSR_DATA_WIDTH-1:N],
                         bus.csr_byteenable[CSR_DATA_WIDTH/8-1:1]};

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (eligible[i]) low_idx = VEC_W'(i);
  end

  always_comb begin
    state_nxt = state;
    load_vec  = 1'b0;
    case (state)
      IDLE: if (|eligible) begin
        state_nxt = REQ;
        load_vec  = 1'b1;
      end
      REQ: if (bus.irq_ack) state_nxt = HOLD;
      HOLD: if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
        // Going straight to REQ keeps the gap at exactly HOLDOFF_CYCLES.
        if (|eligible) begin
          state_nxt = REQ;
          load_vec  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      vec_r    <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (load_vec) vec_r <= low_idx;
    end
  end

  // Clear is applied before set, so a same-cycle edge re-arms the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      sent     <= '0;
      mask_r   <= '0;
      count    <= '0;
    end else begin
      irq_prev <= bus.irq_in;
      pending  <= (pending & ~clr) | rise;
      sent     <= (sent & ~clr) | ack_oh;
      if (wr_en && bus.csr_address == A_MASK)
        mask_r <= bus.csr_writedata[N-1:0] & ~spare_m;
      if (wr_en && bus.csr_address == A_COUNT)
        count <= '0;
      else if (acked && count != '1)
        count <= count + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.csr_address)
      A_STATUS: rd_mux = CSR_DATA_WIDTH'(pending);
      A_MASK:   rd_mux = CSR_DATA_WIDTH'(mask_eff);
      A_SENT:   rd_mux = CSR_DATA_WIDTH'(sent);
      A_COUNT:  rd_mux = CSR_DATA_WIDTH'(count);
      A_RAW:    rd_mux = CSR_DATA_WIDTH'(bus.irq_in);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld  <= bus.csr_read;
      rd_data <= bus.csr_read ? rd_mux : '0;
    end
  end

  assign bus.csr_readdata      = rd_data;
  assign bus.csr_readdatavalid = rd_vld;
  assign bus.csr_waitrequest   = 1'b0;
  assign bus.irq_req           = (state == REQ);
  assign bus.irq_vector        = vec_r;
endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Scoreboard bench for asp_irq_ctrl: stimulus pushes expected reads and
// requests, a negedge monitor pops and compares them.
module tb_asp_irq_ctrl;
  localparam int N = 4, DW = 64, AW = 3, H = 2;
  localparam int STATUS = 0, CLEAR = 1, MASK = 2, SENT = 3, COUNT = 4, RAW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  asp_irq_ctrl_if #(.NUM_IRQ_LINES(N), .CSR_DATA_WIDTH(DW), .CSR_ADDR_WIDTH(AW)) bus ();

  asp_irq_ctrl #(
    .NUM_IRQ_LINES(N), .NUM_IRQ_USED(3), .CSR_DATA_WIDTH(DW),
    .CSR_ADDR_WIDTH(AW), .HOLDOFF_CYCLES(H)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { int vec; int cyc; } irq_exp_t;
  irq_exp_t      irq_q[$];
  logic [DW-1:0] rd_q[$];
  irq_exp_t      e_irq;
  logic [DW-1:0] e_rd;
  int errors = 0, checks = 0, cyc = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) prev_req <= 1'b0;
    else begin
      if (bus.csr_readdatavalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no response", bus.csr_readdata);
        end else begin
          e_rd = rd_q.pop_front();
          chk("csr_read", bus.csr_readdata, e_rd);
        end
      end
      if (bus.irq_req && !prev_req) begin
        if (irq_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL irq_unexpected: got vector %0d at cycle %0d, expected none", bus.irq_vector, cyc);
        end else begin
          e_irq = irq_q.pop_front();
          chk("irq_vector", DW'(bus.irq_vector), DW'(e_irq.vec));
          if (e_irq.cyc >= 0) chk("irq_cycle", DW'(cyc), DW'(e_irq.cyc));
        end
      end
      prev_req <= bus.irq_req;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic csr_wr(input int addr, input logic [DW-1:0] data, input logic [7:0] be, input int push_vec);
    tick();
    bus.csr_write = 1'b1; bus.csr_address = AW'(addr);
    bus.csr_writedata = data; bus.csr_byteenable = be;
    if (push_vec >= 0) irq_q.push_back('{push_vec, cyc + 2});
    tick();
    bus.csr_write = 1'b0; bus.csr_byteenable = '0;
  endtask

  task automatic csr_rd(input int addr, input logic [DW-1:0] exp);
    tick();
    bus.csr_read = 1'b1; bus.csr_address = AW'(addr);
    rd_q.push_back(exp);
    tick();
    bus.csr_read = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] bits, input int push_vec);
    tick();
    bus.irq_in = bus.irq_in | bits;
    if (push_vec >= 0) irq_q.push_back('{push_vec, cyc + 2});
    tick();
    bus.irq_in = bus.irq_in & ~bits;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.irq_req && n < 50) begin
      @(negedge clk); n++;
    end
    if (!bus.irq_req) begin
      checks++; errors++;
      $display("FAIL irq_timeout: got irq_req=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic do_ack(input int next_vec);
    wait_req();
    tick();
    bus.irq_ack = 1'b1;
    if (next_vec >= 0) irq_q.push_back('{next_vec, cyc + 1 + H});
    tick();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.irq_in = '0; bus.csr_address = '0; bus.csr_read = 1'b0; bus.csr_write = 1'b0;
    bus.csr_writedata = '0; bus.csr_byteenable = '0; bus.irq_ack = 1'b0;
    repeat (3) tick();
    chk("rst_irq_req", DW'(bus.irq_req), 0);
    chk("rst_irq_vector", DW'(bus.irq_vector), 0);
    chk("rst_rdvalid", DW'(bus.csr_readdatavalid), 0);
    chk("rst_readdata", bus.csr_readdata, 0);
    chk("rst_waitreq", DW'(bus.csr_waitrequest), 0);
    reset = 1'b0;
    csr_rd(STATUS, 0);
    csr_rd(MASK, 8);

    // Single source pulse, ack, clear
    pulse(4'b0010, 1);
    csr_rd(STATUS, 2);
    do_ack(-1);
    csr_rd(SENT, 2);
    csr_rd(COUNT, 1);
    csr_wr(CLEAR, 2, 8'h01, -1);
    csr_rd(STATUS, 0);
    csr_rd(SENT, 0);

    // Two simultaneous edges: lowest first, then holdoff-spaced second
    pulse(4'b0101, 0);
    do_ack(2);
    do_ack(-1);
    csr_rd(COUNT, 3);
    csr_wr(CLEAR, 5, 8'h01, -1);
    csr_rd(STATUS, 0);

    // Masked source stays pending until unmasked
    csr_wr(MASK, 1, 8'h01, -1);
    csr_rd(MASK, 9);
    pulse(4'b0001, -1);
    repeat (5) tick();
    csr_rd(STATUS, 1);
    csr_wr(MASK, 0, 8'h01, 0);
    do_ack(-1);
    csr_wr(CLEAR, 1, 8'h01, -1);

    // Spare line latches but never requests
    pulse(4'b1000, -1);
    csr_rd(STATUS, 8);
    repeat (4) tick();
    csr_wr(MASK, 0, 8'h01, -1);
    csr_rd(MASK, 8);
    csr_wr(CLEAR, 8, 8'h01, -1);
    csr_rd(STATUS, 0);

    // Clear racing a new edge re-arms the bit
    pulse(4'b0010, 1);
    do_ack(-1);
    repeat (4) tick();
    tick();
    bus.irq_in = 4'b0010;
    bus.csr_write = 1'b1; bus.csr_address = AW'(CLEAR);
    bus.csr_writedata = 2; bus.csr_byteenable = 8'h01;
    irq_q.push_back('{1, cyc + 2});
    tick();
    bus.irq_in = '0; bus.csr_write = 1'b0; bus.csr_byteenable = '0;
    csr_rd(STATUS, 2);
    do_ack(-1);
    csr_wr(CLEAR, 2, 8'h01, -1);
    csr_rd(SENT, 0);

    // Byte enables, RAW, count clear, unmapped address
    csr_wr(COUNT, 0, 8'hFE, -1);
    csr_rd(COUNT, 6);
    csr_wr(COUNT, 64'h1234, 8'h01, -1);
    csr_rd(COUNT, 0);
    csr_wr(MASK, 7, 8'h01, -1);
    tick();
    bus.irq_in = 4'b0110;
    csr_rd(RAW, 6);
    csr_rd(STATUS, 6);
    bus.irq_in = '0;
    csr_wr(CLEAR, 6, 8'h01, -1);
    csr_wr(MASK, 0, 8'hFE, -1);
    csr_rd(MASK, 15);
    csr_wr(MASK, 0, 8'h01, -1);
    csr_rd(MASK, 8);
    csr_wr(6, 64'hFF, 8'hFF, -1);
    csr_rd(7, 0);

    // Reset while a request is outstanding
    pulse(4'b0100, 2);
    wait_req();
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("async_rst_irq_req", DW'(bus.irq_req), 0);
    repeat (2) tick();
    reset = 1'b0;
    for (int a = 0; a < 6; a++) csr_rd(a, (a == MASK) ? 64'd8 : 64'd0);
    repeat (3) tick();

    chk("irq_q_drained", DW'(irq_q.size()), 0);
    chk("rd_q_drained", DW'(rd_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
